// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Control unit for a small 8-bit accumulator CPU. Sequences
//                FETCH/EXEC/MEMWAIT, owns PC, accumulator, carry and the
//                instruction register, and drives the data-memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] insAddr,
    input  logic       insMode,
    input  logic [2:0] insShort,
    input  logic [3:0] insLong,
    input  logic [7:0] dataAddr,
    output logic [7:0] memAddr,
    output logic [7:0] memWdata,
    output logic       memWe,
    input  logic [7:0] memRdata,
    output logic [7:0] acc,
    output logic       carry,
    output logic       halted,
    output logic       busy
);

    // Controller states
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_EXEC    = 3'd2;
    localparam logic [2:0] c_MEMWAIT = 3'd3;
    localparam logic [2:0] c_HALT    = 3'd4;

    // Short-format opcodes (insMode = 0)
    localparam logic [2:0] c_OP_STA = 3'b001;
    localparam logic [2:0] c_OP_LDA = 3'b010;
    localparam logic [2:0] c_OP_CLA = 3'b011;
    localparam logic [2:0] c_OP_COM = 3'b100;
    localparam logic [2:0] c_OP_JMP = 3'b101;

    // Long-format opcodes (insMode = 1)
    localparam logic [3:0] c_OP_ADD = 4'b1000;
    localparam logic [3:0] c_OP_BAN = 4'b1100;
    localparam logic [3:0] c_OP_SHR = 4'b1101;
    localparam logic [3:0] c_OP_CSL = 4'b1110;
    localparam logic [3:0] c_OP_STP = 4'b1111;

    logic [2:0] r_state;
    logic [7:0] r_pc;
    logic [7:0] r_acc;
    logic       r_carry;
    logic       r_ir_mode;
    logic [2:0] r_ir_short;
    logic [3:0] r_ir_long;
    logic [7:0] r_ir_addr;

    logic [2:0] w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_acc_nxt;
    logic       w_carry_nxt;
    logic       w_ir_mode_nxt;
    logic [2:0] w_ir_short_nxt;
    logic [3:0] w_ir_long_nxt;
    logic [7:0] w_ir_addr_nxt;

    logic       w_is_sta, w_is_lda, w_is_cla, w_is_com, w_is_jmp;
    logic       w_is_add, w_is_ban, w_is_shr, w_is_csl, w_is_stp;
    logic [7:0] w_pc_inc;
    logic [8:0] w_sum;

    // Decode the latched instruction; the unused format field is ignored
    assign w_is_sta = ~r_ir_mode & (r_ir_short == c_OP_STA);
    assign w_is_lda = ~r_ir_mode & (r_ir_short == c_OP_LDA);
    assign w_is_cla = ~r_ir_mode & (r_ir_short == c_OP_CLA);
    assign w_is_com = ~r_ir_mode & (r_ir_short == c_OP_COM);
    assign w_is_jmp = ~r_ir_mode & (r_ir_short == c_OP_JMP);
    assign w_is_add =  r_ir_mode & (r_ir_long  == c_OP_ADD);
    assign w_is_ban =  r_ir_mode & (r_ir_long  == c_OP_BAN);
    assign w_is_shr =  r_ir_mode & (r_ir_long  == c_OP_SHR);
    assign w_is_csl =  r_ir_mode & (r_ir_long  == c_OP_CSL);
    assign w_is_stp =  r_ir_mode & (r_ir_long  == c_OP_STP);

    // PC increment wraps naturally at 8 bits; add produces a 9-bit sum
    assign w_pc_inc = r_pc + 8'd1;
    assign w_sum    = {1'b0, r_acc} + {1'b0, memRdata};

    // Next-state and datapath update for every controller state
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_acc_nxt      = r_acc;
        w_carry_nxt    = r_carry;
        w_ir_mode_nxt  = r_ir_mode;
        w_ir_short_nxt = r_ir_short;
        w_ir_long_nxt  = r_ir_long;
        w_ir_addr_nxt  = r_ir_addr;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_FETCH;
                end
            end
            c_FETCH: begin
                w_ir_mode_nxt  = insMode;
                w_ir_short_nxt = insShort;
                w_ir_long_nxt  = insLong;
                w_ir_addr_nxt  = dataAddr;
                w_state_nxt    = c_EXEC;
            end
            c_EXEC: begin
                // Default: single-cycle instruction, advance to the next one
                w_state_nxt = c_FETCH;
                w_pc_nxt    = w_pc_inc;
                if (w_is_cla) begin
                    w_acc_nxt = 8'h00;
                end else if (w_is_com) begin
                    w_acc_nxt = ~r_acc;
                end else if (w_is_csl) begin
                    w_acc_nxt = {r_acc[6:0], r_acc[7]};
                end else if (w_is_shr) begin
                    w_acc_nxt = {1'b0, r_acc[7:1]};
                end else if (w_is_lda || w_is_add) begin
                    // PC advances once the read data is consumed
                    w_state_nxt = c_MEMWAIT;
                    w_pc_nxt    = r_pc;
                end else if (w_is_jmp) begin
                    w_pc_nxt = r_ir_addr;
                end else if (w_is_ban) begin
                    if (r_acc[7]) begin
                        w_pc_nxt = r_ir_addr;
                    end
                end else if (w_is_stp) begin
                    w_state_nxt = c_HALT;
                    w_pc_nxt    = r_pc;
                end
            end
            c_MEMWAIT: begin
                if (w_is_lda) begin
                    w_acc_nxt = memRdata;
                end else if (w_is_add) begin
                    w_acc_nxt   = w_sum[7:0];
                    w_carry_nxt = w_sum[8];
                end
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = c_FETCH;
            end
            c_HALT: begin
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_acc_nxt   = 8'h00;
                    w_carry_nxt = 1'b0;
                    w_state_nxt = c_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Architectural state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_pc       <= RESET_PC;
            r_acc      <= 8'h00;
            r_carry    <= 1'b0;
            r_ir_mode  <= 1'b0;
            r_ir_short <= 3'b000;
            r_ir_long  <= 4'b0000;
            r_ir_addr  <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_acc      <= w_acc_nxt;
            r_carry    <= w_carry_nxt;
            r_ir_mode  <= w_ir_mode_nxt;
            r_ir_short <= w_ir_short_nxt;
            r_ir_long  <= w_ir_long_nxt;
            r_ir_addr  <= w_ir_addr_nxt;
        end
    end

    // Outputs decode only registered state, so they are stable all cycle
    assign insAddr  = r_pc;
    assign acc      = r_acc;
    assign carry    = r_carry;
    assign halted   = (r_state == c_HALT);
    assign busy     = (r_state == c_FETCH) || (r_state == c_EXEC) ||
                      (r_state == c_MEMWAIT);
    assign memWe    = (r_state == c_EXEC) && w_is_sta;
    assign memWdata = memWe ? r_acc : 8'h00;
    // Address is presented in EXEC for memory ops and held through MEMWAIT
    assign memAddr  = (((r_state == c_EXEC) && (w_is_sta || w_is_lda || w_is_add)) ||
                       (r_state == c_MEMWAIT)) ? r_ir_addr : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ctrl
//  Description : Self-checking bench for cpu_ctrl: instruction-level vector
//                table, directed multi-cycle sequences and random programs
//                compared against an ISA-level reference interpreter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl;

    localparam logic [7:0] RP = 8'h40;

    localparam logic [2:0] c_STA = 3'b001;
    localparam logic [2:0] c_LDA = 3'b010;
    localparam logic [2:0] c_CLA = 3'b011;
    localparam logic [2:0] c_COM = 3'b100;
    localparam logic [2:0] c_JMP = 3'b101;
    localparam logic [3:0] c_ADD = 4'b1000;
    localparam logic [3:0] c_BAN = 4'b1100;
    localparam logic [3:0] c_SHR = 4'b1101;
    localparam logic [3:0] c_CSL = 4'b1110;
    localparam logic [3:0] c_STP = 4'b1111;

    typedef struct packed {
        logic       mode;
        logic [2:0] sh;
        logic [3:0] lg;
        logic [7:0] addr;
    } ins_t;

    typedef struct {
        ins_t       ins;
        logic [7:0] a, b, m;
        int         cyc;
        logic [7:0] e_acc;
        logic       e_carry;
        logic [7:0] e_pc;
        logic       e_halt;
        int         e_we;
        logic [7:0] e_waddr, e_wdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] insAddr, memAddr, memWdata, memRdata, acc;
    logic       memWe, carry, halted, busy;
    logic       insMode;
    logic [2:0] insShort;
    logic [3:0] insLong;
    logic [7:0] dataAddr;

    ins_t       prog [256];
    logic [7:0] dmem [256];
    ins_t       cur;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_ctrl #(.RESET_PC(RP)) dut (
        .clk(clk), .rst(rst), .start(start), .insAddr(insAddr),
        .insMode(insMode), .insShort(insShort), .insLong(insLong),
        .dataAddr(dataAddr), .memAddr(memAddr), .memWdata(memWdata),
        .memWe(memWe), .memRdata(memRdata), .acc(acc), .carry(carry),
        .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    // Instruction store with decoder, read combinationally at insAddr
    assign cur      = prog[insAddr];
    assign insMode  = cur.mode;
    assign insShort = cur.sh;
    assign insLong  = cur.lg;
    assign dataAddr = cur.addr;

    // Data memory read port: data valid one cycle after the address
    always @(posedge clk) memRdata <= dmem[memAddr];

    function automatic ins_t si(input logic [2:0] op, input logic [7:0] a);
        si = {1'b0, op, 4'b0000, a};
    endfunction

    function automatic ins_t li(input logic [3:0] op, input logic [7:0] a);
        li = {1'b1, 3'b000, op, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; memory write port commits at the edge that ends the cycle
    task automatic step();
        if (memWe === 1'b1) dmem[memAddr] = memWdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 256; i++) begin
            prog[i] = '0;
            dmem[i] = 8'h00;
        end
    endtask

    // ---------------- ISA-level reference model --------------------------
    logic [7:0] m_pc, m_acc;
    logic       m_carry, m_halt;
    logic [7:0] mm [256];

    // Executes one instruction; reports cycles and whether it stores
    task automatic model_exec(input ins_t in, output int cyc, output bit is_sta);
        int s;
        cyc = 2; is_sta = 0;
        m_pc = m_pc + 8'd1;
        if (!in.mode) begin
            case (in.sh)
                c_STA: begin is_sta = 1; mm[in.addr] = m_acc; end
                c_LDA: begin cyc = 3; m_acc = mm[in.addr]; end
                c_CLA: m_acc = 8'd0;
                c_COM: m_acc = 8'(255 - int'(m_acc));
                c_JMP: m_pc = in.addr;
                default: ;
            endcase
        end else begin
            case (in.lg)
                c_ADD: begin
                    cyc = 3;
                    s = int'(m_acc) + int'(mm[in.addr]);
                    m_acc = 8'(s % 256);
                    m_carry = (s > 255);
                end
                c_BAN: if (m_acc >= 8'd128) m_pc = in.addr;
                c_SHR: m_acc = m_acc / 8'd2;
                c_CSL: m_acc = 8'((int'(m_acc) * 2) % 256 + int'(m_acc) / 128);
                c_STP: begin m_pc = m_pc - 8'd1; m_halt = 1; end
                default: ;
            endcase
        end
    endtask

    vec_t vq[$];
    vec_t v;
    int   we_n, cyc;
    bit   exp_sta;
    logic [7:0] wa, wd;
    ins_t ri;

    initial begin
        rst = 1'b1; start = 1'b0;
        clear_all();

        // ---------------- reset state ----------------
        do_reset();
        check("rst insAddr", insAddr, RP);
        check("rst memAddr", memAddr, 0);
        check("rst memWdata", memWdata, 0);
        check("rst memWe", memWe, 0);
        check("rst acc", acc, 0);
        check("rst carry", carry, 0);
        check("rst halted", halted, 0);
        check("rst busy", busy, 0);
        repeat (3) step();
        check("idle hold busy", busy, 0);
        check("idle hold pc", insAddr, RP);

        // ---------------- single-instruction vector table ----------------
        // Prologue lda 0x10 (a), add 0x11 (b) sets acc=(a+b)%256, carry=(a+b)>255
        //         ins               a      b      m      cyc acc    c     pc        halt we addr   data
        vq.push_back('{li(c_CSL,8'h00), 8'h81, 8'h00, 8'h00, 2, 8'h03, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_SHR,8'h00), 8'h82, 8'hFF, 8'h00, 2, 8'h40, 1'b1, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{si(c_COM,8'h00), 8'h81, 8'h00, 8'h00, 2, 8'h7E, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{si(c_CLA,8'h00), 8'h85, 8'h80, 8'h00, 2, 8'h00, 1'b1, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_BAN,8'h0E), 8'h80, 8'h00, 8'h00, 2, 8'h80, 1'b0, 8'h0E,   1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_BAN,8'h0E), 8'h7F, 8'h00, 8'h00, 2, 8'h7F, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{si(c_JMP,8'h0E), 8'h12, 8'h00, 8'h00, 2, 8'h12, 1'b0, 8'h0E,   1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{si(c_STA,8'h02), 8'h5A, 8'h00, 8'h00, 2, 8'h5A, 1'b0, RP+8'd3, 1'b0, 1, 8'h02, 8'h5A});
        vq.push_back('{si(c_LDA,8'h20), 8'h56, 8'hFF, 8'h3C, 3, 8'h3C, 1'b1, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_ADD,8'h20), 8'hFF, 8'h00, 8'h01, 3, 8'h00, 1'b1, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_ADD,8'h20), 8'h11, 8'hFF, 8'h05, 3, 8'h15, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{16'h0030,        8'h33, 8'h00, 8'h00, 2, 8'h33, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{16'h9930,        8'h33, 8'h00, 8'h00, 2, 8'h33, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{16'h6F30,        8'h33, 8'h00, 8'h00, 2, 8'h33, 1'b0, RP+8'd3, 1'b0, 0, 8'h00, 8'h00});
        vq.push_back('{li(c_STP,8'h00), 8'h44, 8'h00, 8'h00, 2, 8'h44, 1'b0, RP+8'd2, 1'b1, 0, 8'h00, 8'h00});

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            clear_all();
            prog[RP]      = si(c_LDA, 8'h10);
            prog[RP + 1]  = li(c_ADD, 8'h11);
            prog[RP + 2]  = v.ins;
            prog[RP + 3]  = li(c_STP, 8'h00);
            dmem[8'h10]   = v.a;
            dmem[8'h11]   = v.b;
            dmem[8'h20]   = v.m;
            do_reset();
            kick();
            repeat (6) step();
            we_n = 0; wa = 8'h00; wd = 8'h00;
            for (int c = 0; c < v.cyc; c++) begin
                if (memWe === 1'b1) begin we_n++; wa = memAddr; wd = memWdata; end
                step();
            end
            check($sformatf("vec%0d acc", i), acc, v.e_acc);
            check($sformatf("vec%0d carry", i), carry, v.e_carry);
            check($sformatf("vec%0d pc", i), insAddr, v.e_pc);
            check($sformatf("vec%0d halted", i), halted, v.e_halt);
            check($sformatf("vec%0d we_cycles", i), we_n, v.e_we);
            check($sformatf("vec%0d we_addr", i), wa, v.e_waddr);
            check($sformatf("vec%0d we_data", i), wd, v.e_wdata);
        end

        // ---------------- lda/add/stp program with latency ----------------
        clear_all();
        prog[RP]     = si(c_LDA, 8'h01);
        prog[RP + 1] = li(c_ADD, 8'h02);
        prog[RP + 2] = li(c_STP, 8'h00);
        dmem[1] = 8'h0F; dmem[2] = 8'hF3;
        do_reset();
        kick();
        check("prog busy", busy, 1);
        repeat (7) step();
        check("prog not yet halted", halted, 0);
        step();
        check("prog halted", halted, 1);
        check("prog busy in halt", busy, 0);
        check("prog acc", acc, 8'h02);
        check("prog carry", carry, 1);
        check("prog pc", insAddr, RP + 8'd2);
        repeat (2) step();
        check("halt holds", halted, 1);
        kick();
        check("restart pc", insAddr, RP);
        check("restart acc", acc, 0);
        check("restart carry", carry, 0);
        check("restart busy", busy, 1);

        // ---------------- rotate/shift/complement chain ----------------
        clear_all();
        prog[RP]     = si(c_LDA, 8'h10);
        prog[RP + 1] = li(c_ADD, 8'h11);
        prog[RP + 2] = li(c_CSL, 8'h00);
        prog[RP + 3] = li(c_SHR, 8'h00);
        prog[RP + 4] = si(c_COM, 8'h00);
        prog[RP + 5] = si(c_CLA, 8'h00);
        dmem[8'h10] = 8'h82; dmem[8'h11] = 8'hFF;   // acc=0x81, carry=1
        do_reset();
        kick();
        repeat (6) step();
        check("chain start acc", acc, 8'h81);
        repeat (2) step(); check("chain csl", acc, 8'h03); check("chain csl c", carry, 1);
        repeat (2) step(); check("chain shr", acc, 8'h01); check("chain shr c", carry, 1);
        repeat (2) step(); check("chain com", acc, 8'hFE); check("chain com c", carry, 1);
        repeat (2) step(); check("chain cla", acc, 8'h00); check("chain cla c", carry, 1);

        // ---------------- reset during lda MEMWAIT ----------------
        clear_all();
        prog[RP] = si(c_LDA, 8'h01);
        dmem[1]  = 8'h0F;
        do_reset();
        kick();
        repeat (2) step();
        check("memwait addr", memAddr, 8'h01);
        check("memwait we", memWe, 0);
        rst = 1'b1; step(); rst = 1'b0;
        check("mw rst acc", acc, 0);
        check("mw rst pc", insAddr, RP);
        check("mw rst we", memWe, 0);
        check("mw rst busy", busy, 0);
        check("mw rst memAddr", memAddr, 0);
        repeat (3) step();
        check("mw rst stays idle", busy, 0);
        check("mw rst acc later", acc, 0);

        // ---------------- reset during sta EXEC ----------------
        clear_all();
        prog[RP] = si(c_STA, 8'h07);
        do_reset();
        kick();
        step();
        check("sta exec we", memWe, 1);
        check("sta exec addr", memAddr, 8'h07);
        rst = 1'b1; step(); rst = 1'b0;
        check("sta rst we", memWe, 0);
        check("sta rst pc", insAddr, RP);

        // ---------------- PC wrap at 0xFF ----------------
        clear_all();
        prog[RP]    = si(c_JMP, 8'hFF);
        prog[8'hFF] = si(c_CLA, 8'h00);
        do_reset();
        kick();
        repeat (2) step();
        check("wrap jmp pc", insAddr, 8'hFF);
        repeat (2) step();
        check("wrap pc", insAddr, 8'h00);
        check("wrap busy", busy, 1);

        // ---------------- random programs vs reference model ----------------
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 19))
                    0, 1:        ri = si(c_STA, 8'($urandom));
                    2, 3, 4:     ri = si(c_LDA, 8'($urandom));
                    5:           ri = si(c_CLA, 8'($urandom));
                    6:           ri = si(c_COM, 8'($urandom));
                    7:           ri = si(c_JMP, 8'($urandom));
                    8, 9, 10:    ri = li(c_ADD, 8'($urandom));
                    11:          ri = li(c_BAN, 8'($urandom));
                    12:          ri = li(c_SHR, 8'($urandom));
                    13:          ri = li(c_CSL, 8'($urandom));
                    14:          ri = li(c_STP, 8'($urandom));
                    default:     ri = 16'($urandom);
                endcase
                prog[i] = ri;
                dmem[i] = 8'($urandom);
                mm[i]   = dmem[i];
            end
            do_reset();
            kick();
            m_pc = RP; m_acc = 8'h00; m_carry = 1'b0; m_halt = 1'b0;
            for (int k = 0; k < 80; k++) begin
                ri = prog[m_pc];
                model_exec(ri, cyc, exp_sta);
                for (int c = 0; c < cyc; c++) begin
                    check($sformatf("rnd%0d.%0d we c%0d", rnd, k, c), memWe, (exp_sta && c == 1));
                    if (exp_sta && c == 1) begin
                        check($sformatf("rnd%0d.%0d waddr", rnd, k), memAddr, ri.addr);
                        check($sformatf("rnd%0d.%0d wdata", rnd, k), memWdata, m_acc);
                    end
                    step();
                end
                check($sformatf("rnd%0d.%0d pc", rnd, k), insAddr, m_pc);
                check($sformatf("rnd%0d.%0d acc", rnd, k), acc, m_acc);
                check($sformatf("rnd%0d.%0d carry", rnd, k), carry, m_carry);
                check($sformatf("rnd%0d.%0d halted", rnd, k), halted, m_halt);
                if (m_halt) begin
                    kick();
                    m_pc = RP; m_acc = 8'h00; m_carry = 1'b0; m_halt = 1'b0;
                    check($sformatf("rnd%0d.%0d restart pc", rnd, k), insAddr, m_pc);
                    check($sformatf("rnd%0d.%0d restart acc", rnd, k), acc, m_acc);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 8'h00: program counter load value on reset and on restart.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE and HALT.
REQ-006 SHALL have port insAddr  output  8  instruction address to the instruction register, equals PC.
REQ-007 SHALL have port insMode  input  1  decoded format: 0 = short opcode, 1 = long opcode.
REQ-008 SHALL have port insShort  input  3  short opcode: 001 sta, 010 lda, 011 cla, 100 com, 101 jmp.
REQ-009 SHALL have port insLong  input  4  long opcode: 1000 add, 1100 ban, 1101 shr, 1110 csl, 1111 stp.
REQ-010 SHALL have port dataAddr  input  8  decoded operand address.
REQ-011 SHALL have port memAddr  output  8  data memory address.
REQ-012 SHALL have port memWdata  output  8  data memory write data.
REQ-013 SHALL have port memWe  output  1  data memory write enable.
REQ-014 SHALL have port memRdata  input  8  data memory read data, valid one cycle after memAddr is presented.
REQ-015 SHALL have port acc  output  8  accumulator.
REQ-016 SHALL have port carry  output  1  carry flag.
REQ-017 SHALL have port halted  output  1  high while in HALT.
REQ-018 SHALL have port busy  output  1  high in FETCH, EXEC, MEMWAIT.

Function
REQ-019 SHALL implement states IDLE, FETCH, EXEC, MEMWAIT, HALT.
REQ-020 SHALL in IDLE: hold; start=1 -> FETCH.
REQ-021 SHALL in FETCH: present insAddr=PC, latch insMode/insShort/insLong/dataAddr into an internal IR at the edge, -> EXEC.
REQ-022 SHALL in EXEC execute the latched IR: cla acc=0; com acc=~acc; csl acc={acc[6:0],acc[7]}; shr acc={0,acc[7:1]}; each PC+1, -> FETCH.
REQ-023 SHALL for sta in EXEC drive memWe=1, memAddr=IR dataAddr, memWdata=acc for exactly that one cycle; PC+1, -> FETCH.
REQ-024 SHALL for lda/add in EXEC drive memAddr=IR dataAddr, memWe=0, -> MEMWAIT with memAddr held.
REQ-025 SHALL in MEMWAIT: lda acc=memRdata; add {carry,acc}=acc+memRdata (9-bit sum, acc wraps mod 256); PC+1, -> FETCH.
REQ-026 SHALL for jmp set PC=IR dataAddr; ban set PC=IR dataAddr if acc[7]=1 else PC+1; -> FETCH.
REQ-027 SHALL for stp hold PC and acc, -> HALT.
REQ-028 SHALL treat any other opcode combination as no-op: PC+1, -> FETCH.
REQ-029 SHALL update carry only on add; all other instructions leave it unchanged.
REQ-030 SHALL wrap PC 8'hFF+1 -> 8'h00 without flag or stall.
REQ-031 SHALL give latency 2 cycles per instruction (FETCH+EXEC), 3 for lda/add.
REQ-032 SHALL in HALT ignore decoded inputs; start=1 -> PC=RESET_PC, acc=0, carry=0, -> FETCH.
REQ-033 SHALL ignore start outside IDLE and HALT.
REQ-034 SHALL drive memWe=0 in every state other than EXEC with sta latched; memAddr/memWdata SHALL be 0 when unused.

Reset
REQ-035 SHALL on rst=1 at an edge set state=IDLE, PC=RESET_PC, acc=0, carry=0, IR=0, from any state including mid-lda/add MEMWAIT or sta EXEC.
REQ-036 SHALL take rst priority over start and over any pending instruction; memWe SHALL be 0 in the cycle following the reset edge.
REQ-037 SHALL hold outputs after reset: insAddr=RESET_PC, memAddr=0, memWdata=0, memWe=0, acc=0, carry=0, halted=0, busy=0.

Verification
REQ-038 SHALL cover: program lda[1] (mem[1]=8'h0F), add[2] (mem[2]=8'hF3), stp -> acc=8'h02, carry=1, halted=1 after 3+3+2 cycles from start.
REQ-039 SHALL cover: acc=8'h81, csl -> 8'h03; shr -> 8'h01; com -> 8'hFE; cla -> 8'h00; carry unchanged throughout.
REQ-040 SHALL cover: ban to 8'h0E with acc=8'h80 -> PC=8'h0E; with acc=8'h7F -> PC+1; jmp 8'h0E -> PC=8'h0E.
REQ-041 SHALL cover: sta 8'h02 with acc=8'h5A -> memWe=1 for one cycle, memAddr=8'h02, memWdata=8'h5A.
REQ-042 SHALL cover: rst asserted during MEMWAIT of lda -> acc stays 0, state IDLE, insAddr=RESET_PC, memWe=0.
REQ-043 SHALL cover: PC=8'hFF executing cla -> PC=8'h00; start in HALT -> restart at RESET_PC with acc=0.
